// File: rtl/sprite_frame_engine.sv
// sprite_frame_engine
// Multi-sprite erase/redraw sequencer for the 160x120 runner game. It sits between
// the game control FSM and vga_adapter. A frame_tick accepted in IDLE snapshots all
// sprite slots. Then, for each slot in ascending order, the engine erases the box that
// was drawn last frame and draws the box at the new position. It emits one pixel per
// clock in row-major order. Pixels that fall off-screen keep their cycle but are not
// plotted.
//
// Optional build macro: SPRITE_COLLIDE_EN. When it is defined, the engine adds a
// box-overlap test between slot 0 (the player) and every other enabled slot, and
// reports the result on hit. When it is undefined, hit is tied to 0.
//
// Ports
//   clock       system clock
//   reset       synchronous, active-high reset
//   frame_tick  frame start request, accepted only while idle
//   spr_x       top-left x per slot, slot i = bits [8i+7:8i]
//   spr_y       top-left y per slot, slot i = bits [7i+6:7i]
//   spr_colour  draw colour per slot
//   spr_en      slot visible this frame
//   busy        high from the cycle after acceptance until done
//   done        one-cycle pulse when the frame is complete
//   x, y        vga_adapter pixel address
//   colour      vga_adapter pixel colour
//   plot        vga_adapter write enable
//   hit         player collision flag, held until the next frame's latch
module sprite_frame_engine #(
    parameter int                  NUM_SPRITES = 2,
    parameter int                  SPR_W       = 4,
    parameter int                  SPR_H       = 4,
    parameter int                  SCREEN_W    = 160,
    parameter int                  SCREEN_H    = 120,
    parameter int                  COLOUR_W    = 3,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = '0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            frame_tick,
    input  logic [8*NUM_SPRITES-1:0]        spr_x,
    input  logic [7*NUM_SPRITES-1:0]        spr_y,
    input  logic [COLOUR_W*NUM_SPRITES-1:0] spr_colour,
    input  logic [NUM_SPRITES-1:0]          spr_en,
    output logic                            busy,
    output logic                            done,
    output logic [7:0]                      x,
    output logic [6:0]                      y,
    output logic [COLOUR_W-1:0]             colour,
    output logic                            plot,
    output logic                            hit
);

    // Phases are numbered 2*slot (erase) and 2*slot+1 (draw), so the walk order is
    // simply ascending phase index.
    localparam int NPH  = 2 * NUM_SPRITES;
    localparam int PH_W = $clog2(NPH + 1);
    localparam int PXW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int PYW  = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t state, state_d;
    logic [PH_W-1:0] ph, ph_d;
    logic [PXW-1:0]  px, px_d;
    logic [PYW-1:0]  py, py_d;

    logic [7:0]          new_x   [NUM_SPRITES];
    logic [6:0]          new_y   [NUM_SPRITES];
    logic [COLOUR_W-1:0] new_col [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] new_en;
    logic [7:0]          prev_x  [NUM_SPRITES];
    logic [6:0]          prev_y  [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] drawn;

    // During LATCH the snapshot is still being captured. The first pixel is chosen in
    // that same cycle, so it has to look at the live inputs rather than the registers.
    logic [7:0]          cur_x   [NUM_SPRITES];
    logic [6:0]          cur_y   [NUM_SPRITES];
    logic [COLOUR_W-1:0] cur_col [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] cur_en;

    always_comb begin
        cur_en = (state == S_LATCH) ? spr_en : new_en;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            cur_x[i]   = (state == S_LATCH) ? spr_x[8*i +: 8] : new_x[i];
            cur_y[i]   = (state == S_LATCH) ? spr_y[7*i +: 7] : new_y[i];
            cur_col[i] = (state == S_LATCH) ? spr_colour[COLOUR_W*i +: COLOUR_W] : new_col[i];
        end
    end

    // Returns {found, index} of the lowest active phase at or after start. An erase
    // phase is active only if its slot was drawn last frame. A draw phase is active
    // only if its slot is enabled this frame. Skipped phases therefore cost no cycles.
    function automatic logic [PH_W:0] find_phase(input logic [PH_W-1:0]     start,
                                                 input logic [NUM_SPRITES-1:0] drawn_v,
                                                 input logic [NUM_SPRITES-1:0] en_v);
        logic [PH_W:0] r;
        r = '0;
        for (int k = NPH - 1; k >= 0; k--) begin
            if (k >= int'(start) && ((k % 2 == 1) ? en_v[k/2] : drawn_v[k/2]))
                r = {1'b1, PH_W'(k)};
        end
        return r;
    endfunction

    logic [PH_W-1:0] fp_start;
    logic [PH_W:0]   fp;
    logic            advance;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can leave
        // it unassigned and infer a latch.
        state_d  = state;
        ph_d     = ph;
        px_d     = px;
        py_d     = py;
        advance  = 1'b0;
        fp_start = (state == S_LATCH) ? '0 : ph + PH_W'(1);
        fp       = find_phase(fp_start, drawn, cur_en);

        case (state)
            S_IDLE:  if (frame_tick) state_d = S_LATCH;
            S_LATCH: advance = 1'b1;
            S_ERASE, S_DRAW: begin
                if (px == PXW'(SPR_W - 1)) begin
                    px_d = '0;
                    if (py == PYW'(SPR_H - 1)) begin
                        py_d    = '0;
                        advance = 1'b1;
                    end else begin
                        py_d = py + PYW'(1);
                    end
                end else begin
                    px_d = px + PXW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (fp[PH_W]) begin
                state_d = fp[0] ? S_DRAW : S_ERASE;
                ph_d    = fp[PH_W-1:0];
                px_d    = '0;
                py_d    = '0;
            end else begin
                state_d = S_DONE;
            end
        end
    end

    // Pixel outputs are computed from the next state and registered. As a result, the
    // x/y/colour/plot values seen in a cycle describe that cycle's pixel.
    logic [7:0]          base_x;
    logic [6:0]          base_y;
    logic [COLOUR_W-1:0] col_sel;
    logic [8:0]          sum_x;
    logic [7:0]          sum_y;
    logic                pix_state;
    logic                plot_d;

    always_comb begin
        base_x  = '0;
        base_y  = '0;
        col_sel = BG_COLOUR;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (int'(ph_d[PH_W-1:1]) == i) begin
                if (ph_d[0]) begin
                    base_x  = cur_x[i];
                    base_y  = cur_y[i];
                    col_sel = cur_col[i];
                end else begin
                    base_x  = prev_x[i];
                    base_y  = prev_y[i];
                    col_sel = BG_COLOUR;
                end
            end
        end
        // The sums are one bit wider than the coordinates, so a box straddling the
        // edge is clipped instead of wrapping to the far side of the screen.
        sum_x     = {1'b0, base_x} + 9'(px_d);
        sum_y     = {1'b0, base_y} + 8'(py_d);
        pix_state = (state_d == S_ERASE) || (state_d == S_DRAW);
        plot_d    = pix_state && (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state  <= S_IDLE;
            ph     <= '0;
            px     <= '0;
            py     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            new_en <= '0;
            drawn  <= '0;
        end else begin
            state  <= state_d;
            ph     <= ph_d;
            px     <= px_d;
            py     <= py_d;
            busy   <= (state_d != S_IDLE);
            done   <= (state_d == S_DONE);
            plot   <= plot_d;
            x      <= pix_state ? sum_x[7:0] : '0;
            y      <= pix_state ? sum_y[6:0] : '0;
            colour <= pix_state ? col_sel : '0;
            if (state == S_LATCH) new_en <= spr_en;
            // Each slot's erase reads only its own prev/drawn entry. Committing all
            // slots once at DONE is therefore the same as committing each slot after
            // its own draw.
            if (state == S_DONE) drawn <= new_en;
        end
    end

    // NOTE: position storage has no reset. It is only read behind drawn[] or new_en[],
    // and both of those are reset, so clearing the storage would buy nothing.
    always_ff @(posedge clock) begin
        if (state == S_LATCH) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                new_x[i]   <= spr_x[8*i +: 8];
                new_y[i]   <= spr_y[7*i +: 7];
                new_col[i] <= spr_colour[COLOUR_W*i +: COLOUR_W];
            end
        end
        if (state == S_DONE) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                prev_x[i] <= new_x[i];
                prev_y[i] <= new_y[i];
            end
        end
    end

`ifdef SPRITE_COLLIDE_EN
    // Two boxes of identical size overlap exactly when both axis distances are
    // smaller than the box dimension.
    logic       collide_d;
    logic [7:0] dx;
    logic [6:0] dy;

    always_comb begin
        collide_d = 1'b0;
        dx        = '0;
        dy        = '0;
        for (int j = 1; j < NUM_SPRITES; j++) begin
            dx = (spr_x[7:0] > spr_x[8*j +: 8]) ? spr_x[7:0] - spr_x[8*j +: 8]
                                                 : spr_x[8*j +: 8] - spr_x[7:0];
            dy = (spr_y[6:0] > spr_y[7*j +: 7]) ? spr_y[6:0] - spr_y[7*j +: 7]
                                                 : spr_y[7*j +: 7] - spr_y[6:0];
            if (spr_en[0] && spr_en[j] && (dx < 8'(SPR_W)) && (dy < 7'(SPR_H)))
                collide_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            hit <= 1'b0;
        else if (state == S_LATCH)
            hit <= collide_d;
    end
`else
    assign hit = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_frame_engine.sv
// Directed bench for sprite_frame_engine with the default parameters: 2 slots,
// 4x4 boxes, 160x120 screen and 3-bit colour. Each frame records every plotted pixel
// and the cycle (counted from the accepting edge) on which done pulses.
module tb_sprite_frame_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [15:0] spr_x;
    logic [13:0] spr_y;
    logic [5:0]  spr_colour;
    logic [1:0]  spr_en;
    logic        busy;
    logic        done;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        hit;

`ifdef SPRITE_COLLIDE_EN
    localparam int EXP_HIT = 1;
`else
    localparam int EXP_HIT = 0;
`endif

    sprite_frame_engine dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .spr_x      (spr_x),
        .spr_y      (spr_y),
        .spr_colour (spr_colour),
        .spr_en     (spr_en),
        .busy       (busy),
        .done       (done),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .hit        (hit)
    );

    always #5 clock = ~clock;

    typedef struct {
        int px;
        int py;
        int pc;
    } pix_t;

    pix_t pixq[$];
    int   done_cyc;
    int   lat_busy;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compares a recorded pixel, packed as x*65536 + y*256 + colour, or -1 if the
    // pixel is missing.
    task automatic check_pix(input string tag, input int idx, input int ex, input int ey,
                             input int ec);
        int got;
        got = -1;
        if (idx < pixq.size())
            got = pixq[idx].px * 65536 + pixq[idx].py * 256 + pixq[idx].pc;
        check(tag, got, ex * 65536 + ey * 256 + ec);
    endtask

    task automatic set_spr(input int i, input int sx, input int sy, input int sc,
                           input logic en);
        spr_x[8*i +: 8]      = 8'(sx);
        spr_y[7*i +: 7]      = 7'(sy);
        spr_colour[3*i +: 3] = 3'(sc);
        spr_en[i]            = en;
    endtask

    // Issues a tick, holds it for hold cycles, and records pixels until done.
    task automatic run_frame(input int hold);
        int   cyc;
        pix_t p;
        pixq.delete();
        done_cyc = -1;
        lat_busy = -1;
        @(negedge clock);
        frame_tick = 1'b1;
        @(posedge clock);
        cyc = 0;
        while (cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) lat_busy = int'(busy);
            if (cyc >= hold) frame_tick = 1'b0;
            if (plot) begin
                p.px = int'(x);
                p.py = int'(y);
                p.pc = int'(colour);
                pixq.push_back(p);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        frame_tick = 1'b0;
        if (done_cyc < 0) check("frame_timeout", cyc, -1);
    endtask

    initial begin
        int cyc;
        reset      = 1'b1;
        frame_tick = 1'b0;
        spr_x      = '0;
        spr_y      = '0;
        spr_colour = '0;
        spr_en     = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_xyc", int'(x) + int'(y) + int'(colour), 0);
        reset = 1'b0;

        // Frame 1: nothing drawn yet, so there are only two draws.
        set_spr(0, 20, 60, 4, 1'b1);
        set_spr(1, 100, 115, 1, 1'b1);
        run_frame(1);
        check("t1_latch_busy", lat_busy, 1);
        check("t1_done_cyc", done_cyc, 34);
        check("t1_plots", pixq.size(), 32);
        check_pix("t1_pix0", 0, 20, 60, 4);
        check_pix("t1_pix15", 15, 23, 63, 4);
        check_pix("t1_pix16", 16, 100, 115, 1);
        check_pix("t1_pix31", 31, 103, 118, 1);
        @(negedge clock);
        check("t1_busy_drop", int'(busy), 0);
        check("t1_done_pulse", int'(done), 0);

        // Frame 2: slot 0 moves up two rows, and both slots are erased and redrawn.
        set_spr(0, 20, 58, 4, 1'b1);
        run_frame(1);
        check("t2_done_cyc", done_cyc, 66);
        check("t2_plots", pixq.size(), 64);
        check_pix("t2_pix0", 0, 20, 60, 0);
        check_pix("t2_pix15", 15, 23, 63, 0);
        check_pix("t2_pix16", 16, 20, 58, 4);
        check_pix("t2_pix31", 31, 23, 61, 4);
        check_pix("t2_pix32", 32, 100, 115, 0);
        check_pix("t2_pix48", 48, 100, 115, 1);

        // Frame 3: slot 1 is disabled, so it is erased but not redrawn.
        set_spr(1, 100, 115, 1, 1'b0);
        run_frame(1);
        check("t3_done_cyc", done_cyc, 50);
        check("t3_plots", pixq.size(), 48);
        check_pix("t3_pix32", 32, 100, 115, 0);
        check_pix("t3_pix47", 47, 103, 118, 0);
        run_frame(1);
        check("t3b_done_cyc", done_cyc, 34);
        check("t3b_plots", pixq.size(), 32);
        check_pix("t3b_pix16", 16, 20, 58, 4);

        // Right-edge clipping: only columns 158 and 159 are visible.
        set_spr(0, 158, 60, 4, 1'b1);
        run_frame(1);
        check("t6_done_cyc", done_cyc, 34);
        check("t6_plots", pixq.size(), 24);
        check_pix("t6_pix16", 16, 158, 60, 4);
        check_pix("t6_pix17", 17, 159, 60, 4);
        check_pix("t6_pix18", 18, 158, 61, 4);
        check_pix("t6_pix23", 23, 159, 63, 4);

        // Bottom-edge clipping: only rows 118 and 119 are visible.
        set_spr(0, 50, 118, 4, 1'b1);
        run_frame(1);
        check("t6b_done_cyc", done_cyc, 34);
        check("t6b_plots", pixq.size(), 16);
        check_pix("t6b_pix0", 0, 158, 60, 0);
        check_pix("t6b_pix7", 7, 159, 63, 0);
        check_pix("t6b_pix8", 8, 50, 118, 4);
        check_pix("t6b_pix15", 15, 53, 119, 4);

        // frame_tick held high for 20 busy cycles. The repeated ticks must be ignored
        // and the frame length must not change. Slot 1 is enabled but was not drawn
        // last frame, so it gets no erase.
        set_spr(0, 20, 60, 4, 1'b1);
        set_spr(1, 100, 115, 1, 1'b1);
        run_frame(20);
        check("t4_done_cyc", done_cyc, 50);
        check("t4_plots", pixq.size(), 40);
        check_pix("t4_pix0", 0, 50, 118, 0);
        check_pix("t4_pix8", 8, 20, 60, 4);
        check_pix("t4_pix24", 24, 100, 115, 1);
        @(negedge clock);
        check("t4_busy_drop", int'(busy), 0);
        @(negedge clock);
        check("t4_no_retrigger", int'(busy), 0);

        // Reset at pixel 10 with frame_tick still high.
        @(negedge clock);
        frame_tick = 1'b1;
        @(posedge clock);
        cyc = 0;
        while (cyc < 11) begin
            @(negedge clock);
            cyc++;
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset      = 1'b0;
        frame_tick = 1'b0;
        check("t4r_plot", int'(plot), 0);
        check("t4r_busy", int'(busy), 0);
        @(negedge clock);
        check("t4r_idle", int'(busy), 0);
        // Reset cleared drawn[], so this frame has no erase phase.
        run_frame(1);
        check("t4r_done_cyc", done_cyc, 34);
        check("t4r_plots", pixq.size(), 32);
        check_pix("t4r_pix0", 0, 20, 60, 4);

        // Collision tests: hit is 1 only when the build enables the collision feature.
        set_spr(1, 23, 63, 1, 1'b1);
        run_frame(1);
        check("t5_hit_corner", int'(hit), EXP_HIT);
        set_spr(1, 17, 57, 1, 1'b1);
        run_frame(1);
        check("t5_hit_upleft", int'(hit), EXP_HIT);
        repeat (3) @(negedge clock);
        check("t5_hit_hold", int'(hit), EXP_HIT);
        set_spr(1, 24, 60, 1, 1'b1);
        run_frame(1);
        check("t5_hit_apart", int'(hit), 0);

        // All slots disabled: the first frame only erases, the second frame is
        // LATCH followed directly by DONE.
        set_spr(0, 20, 60, 4, 1'b0);
        set_spr(1, 24, 60, 1, 1'b0);
        run_frame(1);
        check("t7_done_cyc", done_cyc, 34);
        check("t7_plots", pixq.size(), 32);
        check_pix("t7_pix16", 16, 24, 60, 0);
        run_frame(1);
        check("t7b_done_cyc", done_cyc, 2);
        check("t7b_plots", pixq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
